data_memory_ctrl: RTL and testbench

Data-memory responder for the pipelined MIPS core: it serves the load/store requests the MEM stage issues, with byte/halfword/word access and sign or zero extension. It also streams the whole memory contents to the debug unit over a ready/valid dump port once the pipeline is halted. It sits between the MEM stage and the debug unit and owns the data memory array.

---
 rtl/data_memory_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Data memory for the MIPS MEM stage: byte/half/word loads and stores with extension.
// Optional halted-pipeline memory dump port to the debug unit, built when DMEM_DUMP_EN is defined.
module data_memory_ctrl #(
    parameter int unsigned NB_ADDR   = 32,
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned NB_DEPTH  = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [NB_ADDR-1:0] i_address,
    input  logic [NB_DATA-1:0] i_write_data,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    output logic [NB_DATA-1:0] o_read_data,
    output logic               o_read_valid,
    output logic               o_misaligned,
    input  logic               i_du_dump_start,
    input  logic               i_du_ready,
    output logic [NB_DATA-1:0] o_du_data,
    output logic [NB_ADDR-1:0] o_du_addr,
    output logic               o_du_valid,
    output logic               o_du_done,
    output logic               o_busy
);
    localparam int unsigned NB_BYTES = NB_DATA / 8;
    localparam logic [1:0]  SZ_BYTE  = 2'b00;
    localparam logic [1:0]  SZ_HALF  = 2'b01;

    logic [NB_DATA-1:0]  mem [MEM_DEPTH];

    logic [NB_DEPTH-1:0] word_idx_c;
    logic [1:0]          offset_c;
    logic                misaligned_c;
    logic                dump_active_c;
    logic                serve_c;
    logic                wr_en_c;
    logic [NB_BYTES-1:0] be_c;
    logic [NB_DATA-1:0]  wr_word_c;
    logic [NB_DATA-1:0]  rd_word_c;
    logic [7:0]          ld_byte_c;
    logic [15:0]         ld_half_c;
    logic [NB_DATA-1:0]  ld_ext_c;

    logic [NB_DATA-1:0]  read_data_q, read_data_d;
    logic                read_valid_q, read_valid_d;
    logic                misaligned_q, misaligned_d;

    logic                unused_addr_ok;
    assign unused_addr_ok = ^i_address[NB_ADDR-1:NB_DEPTH+2];

    // Request decode: word index wraps modulo memory size, lanes are little-endian.
    always_comb begin
        word_idx_c = i_address[NB_DEPTH+1:2];
        offset_c   = i_address[1:0];
        case (i_size)
            SZ_BYTE: misaligned_c = 1'b0;
            SZ_HALF: misaligned_c = offset_c[0];
            default: misaligned_c = |offset_c;
        endcase
        serve_c = !dump_active_c && (i_mem_read || i_mem_write);
        wr_en_c = !dump_active_c && i_mem_write && !misaligned_c;
        case (i_size)
            SZ_BYTE: begin
                be_c      = NB_BYTES'(1) << offset_c;
                wr_word_c = NB_DATA'({4{i_write_data[7:0]}});
            end
            SZ_HALF: begin
                be_c      = offset_c[1] ? NB_BYTES'(4'b1100) : NB_BYTES'(4'b0011);
                wr_word_c = NB_DATA'({2{i_write_data[15:0]}});
            end
            default: begin
                be_c      = '1;
                wr_word_c = i_write_data;
            end
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        rd_word_c = mem[word_idx_c];
        ld_byte_c = rd_word_c[{offset_c, 3'b000} +: 8];
        ld_half_c = rd_word_c[{offset_c[1], 4'b0000} +: 16];
        case (i_size)
            SZ_BYTE: ld_ext_c = {{(NB_DATA-8){ld_byte_c[7] & !i_unsigned}}, ld_byte_c};
            SZ_HALF: ld_ext_c = {{(NB_DATA-16){ld_half_c[15] & !i_unsigned}}, ld_half_c};
            default: ld_ext_c = rd_word_c;
        endcase
    end

    // A store wins over a simultaneous load; misaligned loads return zero.
    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        misaligned_d = 1'b0;
        if (serve_c) begin
            misaligned_d = misaligned_c;
            if (!i_mem_write) begin
                read_valid_d = 1'b1;
                read_data_d  = misaligned_c ? '0 : ld_ext_c;
            end
        end
    end

    // Memory array is not reset.
    always_ff @(posedge i_clock) begin
        if (wr_en_c) begin
            for (int b = 0; b < int'(NB_BYTES); b++) begin
                if (be_c[b]) mem[word_idx_c][8*b +: 8] <= wr_word_c[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_read_data  = read_data_q;
    assign o_read_valid = read_valid_q;
    assign o_misaligned = misaligned_q;

`ifdef DMEM_DUMP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PRESENT, ST_DONE} state_e;

    state_e              state_q, state_d;
    logic [NB_DEPTH-1:0] cnt_q, cnt_d;
    logic [NB_DATA-1:0]  du_data_q, du_data_d;
    logic [NB_ADDR-1:0]  du_addr_q, du_addr_d;
    logic                du_valid_q, du_valid_d;
    logic                du_done_q, du_done_d;
    logic                busy_q, busy_d;

    assign dump_active_c = (state_q != ST_IDLE);

    // Dump sequencer: fetch one word, hold it until accepted, advance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        du_data_d = du_data_q;
        du_addr_d = du_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_du_dump_start) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                du_data_d = mem[cnt_q];
                du_addr_d = NB_ADDR'({cnt_q, 2'b00});
                state_d   = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (i_du_ready) begin
                    if (cnt_q == NB_DEPTH'(MEM_DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + NB_DEPTH'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        du_valid_d = (state_d == ST_PRESENT);
        du_done_d  = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            du_data_q  <= '0;
            du_addr_q  <= '0;
            du_valid_q <= 1'b0;
            du_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            du_data_q  <= du_data_d;
            du_addr_q  <= du_addr_d;
            du_valid_q <= du_valid_d;
            du_done_q  <= du_done_d;
            busy_q     <= busy_d;
        end
    end

    assign o_du_data  = du_data_q;
    assign o_du_addr  = du_addr_q;
    assign o_du_valid = du_valid_q;
    assign o_du_done  = du_done_q;
    assign o_busy     = busy_q;
`else
    logic unused_du_ok;
    assign unused_du_ok  = i_du_dump_start ^ i_du_ready;
    assign dump_active_c = 1'b0;
    assign o_du_data     = '0;
    assign o_du_addr     = '0;
    assign o_du_valid    = 1'b0;
    assign o_du_done     = 1'b0;
    assign o_busy        = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: load/store lanes, extension, alignment, wrap,
// and (with DMEM_DUMP_EN) the dump handshake, backpressure and reset abort.
module tb_data_memory_ctrl;
    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [31:0] i_address = '0;
    logic [31:0] i_write_data = '0;
    logic [1:0]  i_size = 2'b10;
    logic        i_unsigned = 1'b0;
    logic [31:0] o_read_data;
    logic        o_read_valid;
    logic        o_misaligned;
    logic        i_du_dump_start = 1'b0;
    logic        i_du_ready = 1'b0;
    logic [31:0] o_du_data;
    logic [31:0] o_du_addr;
    logic        o_du_valid;
    logic        o_du_done;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_ctrl #(
        .NB_ADDR(32), .NB_DATA(32), .MEM_DEPTH(256), .NB_DEPTH(8)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_address(i_address), .i_write_data(i_write_data),
        .i_size(i_size), .i_unsigned(i_unsigned),
        .o_read_data(o_read_data), .o_read_valid(o_read_valid), .o_misaligned(o_misaligned),
        .i_du_dump_start(i_du_dump_start), .i_du_ready(i_du_ready),
        .o_du_data(o_du_data), .o_du_addr(o_du_addr), .o_du_valid(o_du_valid),
        .o_du_done(o_du_done), .o_busy(o_busy)
    );

    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request cycle; on return the response cycle is current.
    task automatic mem_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz, input logic uns);
        @(negedge i_clock);
        i_mem_read = rd; i_mem_write = wr; i_address = addr;
        i_write_data = wd; i_size = sz; i_unsigned = uns;
        @(negedge i_clock);
        i_mem_read = 1'b0; i_mem_write = 1'b0;
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic exp_mis);
        mem_req(1'b0, 1'b1, addr, wd, sz, 1'b0);
        check_eq({tag, "_valid"}, 32'(o_read_valid), 32'd0);
        check_eq({tag, "_mis"}, 32'(o_misaligned), 32'(exp_mis));
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] exp, input logic exp_mis);
        mem_req(1'b1, 1'b0, addr, 32'h0, sz, uns);
        if (!exp_mis) check_eq({tag, "_valid"}, 32'(o_read_valid), 32'd1);
        check_eq({tag, "_data"}, o_read_data, exp);
        check_eq({tag, "_mis"}, 32'(o_misaligned), 32'(exp_mis));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rdata"}, o_read_data, 32'h0);
        check_eq({tag, "_rvalid"}, 32'(o_read_valid), 32'h0);
        check_eq({tag, "_mis"}, 32'(o_misaligned), 32'h0);
        check_eq({tag, "_du_data"}, o_du_data, 32'h0);
        check_eq({tag, "_du_addr"}, o_du_addr, 32'h0);
        check_eq({tag, "_du_valid"}, 32'(o_du_valid), 32'h0);
        check_eq({tag, "_du_done"}, 32'(o_du_done), 32'h0);
        check_eq({tag, "_busy"}, 32'(o_busy), 32'h0);
    endtask

`ifdef DMEM_DUMP_EN
    logic [31:0] model [256];
    int          cyc;
    int          n_hs;
    logic        pv, pr, saw_done, reset_hit;
    logic [31:0] pd, pa;

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'h5A, b, ~b, b ^ 8'h3C};
    endfunction
`endif

    initial begin
        repeat (3) @(negedge i_clock);
        check_outputs_zero("reset");
        i_reset = 1'b1;

        store("sw10", 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        load("lw10", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

        store("sb13", 32'h13, 32'h1234567F, 2'b00, 1'b0);
        load("lb13", 32'h13, 2'b00, 1'b0, 32'h0000007F, 1'b0);
        load("lb12", 32'h12, 2'b00, 1'b0, 32'hFFFFFFAD, 1'b0);
        load("lbu12", 32'h12, 2'b00, 1'b1, 32'h000000AD, 1'b0);
        load("lw10b", 32'h10, 2'b10, 1'b0, 32'h7FADBEEF, 1'b0);

        // Store-only cycle keeps the last load value
        store("sw_hold", 32'h40, 32'h01020304, 2'b10, 1'b0);
        check_eq("rdata_hold", o_read_data, 32'h7FADBEEF);

        load("lh11", 32'h11, 2'b01, 1'b0, 32'h0, 1'b1);
        store("sw12_mis", 32'h12, 32'h12345678, 2'b10, 1'b1);
        load("lw10c", 32'h10, 2'b10, 1'b0, 32'h7FADBEEF, 1'b0);

        store("sw14", 32'h14, 32'h11223344, 2'b10, 1'b0);
        store("sh16", 32'h16, 32'hFFFF8001, 2'b01, 1'b0);
        load("lh16", 32'h16, 2'b01, 1'b0, 32'hFFFF8001, 1'b0);
        load("lhu16", 32'h16, 2'b01, 1'b1, 32'h00008001, 1'b0);
        load("lh14", 32'h14, 2'b01, 1'b0, 32'h00003344, 1'b0);
        load("lsz3", 32'h14, 2'b11, 1'b1, 32'h80013344, 1'b0);
        store("sb15", 32'h15, 32'h000000F0, 2'b00, 1'b0);
        load("lw14", 32'h14, 2'b10, 1'b0, 32'h8001F044, 1'b0);
        load("lw_sz3_mis", 32'h15, 2'b11, 1'b0, 32'h0, 1'b1);

        store("sw400", 32'h400, 32'hA5A5A5A5, 2'b10, 1'b0);
        load("lw000", 32'h000, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0);

        mem_req(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0);
        check_eq("rdwr_valid", 32'(o_read_valid), 32'd0);
        load("lw20", 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_DUMP_EN
        for (int i = 0; i < 256; i++) begin
            model[i] = pat(i);
            mem_req(1'b0, 1'b1, 32'(i * 4), model[i], 2'b10, 1'b0);
        end

        // Dump with ready held high; a store in the middle must be dropped
        i_du_ready = 1'b1;
        @(negedge i_clock);
        i_du_dump_start = 1'b1;
        @(negedge i_clock);
        i_du_dump_start = 1'b0;
        cyc = 1;
        n_hs = 0;
        check_eq("dump1_busy", 32'(o_busy), 32'd1);
        check_eq("dump1_fetch_valid", 32'(o_du_valid), 32'd0);
        while (n_hs < 256 && cyc < 2000) begin
            if (o_du_valid) begin
                check_eq("dump1_addr", o_du_addr, 32'(n_hs * 4));
                check_eq("dump1_data", o_du_data, model[n_hs]);
                n_hs++;
                if (n_hs == 101) begin
                    i_mem_write = 1'b1; i_address = 32'h0;
                    i_write_data = 32'hBADBAD00; i_size = 2'b10;
                end
            end
            @(negedge i_clock);
            cyc++;
            i_mem_write = 1'b0;
        end
        check_eq("dump1_handshakes", 32'(n_hs), 32'd256);
        check_eq("dump1_done_cycle", 32'(cyc), 32'd513);
        check_eq("dump1_done", 32'(o_du_done), 32'd1);
        check_eq("dump1_done_valid", 32'(o_du_valid), 32'd0);
        @(negedge i_clock);
        check_eq("dump1_done_pulse", 32'(o_du_done), 32'd0);
        check_eq("dump1_idle_busy", 32'(o_busy), 32'd0);
        load("dump1_dropped_sw", 32'h0, 2'b10, 1'b0, model[0], 1'b0);

        // Dump with ready toggling every 3 cycles, aborted by reset at word 5
        i_du_ready = 1'b0;
        @(negedge i_clock);
        i_du_dump_start = 1'b1;
        @(negedge i_clock);
        i_du_dump_start = 1'b0;
        cyc = 0; pv = 1'b0; pr = 1'b0; pd = '0; pa = '0;
        saw_done = 1'b0; reset_hit = 1'b0;
        while (!reset_hit && cyc < 300) begin
            if (pv && !pr) begin
                check_eq("bp_valid_held", 32'(o_du_valid), 32'd1);
                check_eq("bp_data_held", o_du_data, pd);
                check_eq("bp_addr_held", o_du_addr, pa);
            end
            if (o_du_valid) check_eq("bp_data", o_du_data, model[o_du_addr[9:2]]);
            if (o_du_done) saw_done = 1'b1;
            if (o_du_valid && o_du_addr == 32'h14) begin
                i_reset = 1'b0;
                #1;
                check_outputs_zero("abort");
                reset_hit = 1'b1;
            end else begin
                if (cyc % 3 == 2) i_du_ready = ~i_du_ready;
                pv = o_du_valid; pd = o_du_data; pa = o_du_addr; pr = i_du_ready;
                @(negedge i_clock);
                cyc++;
            end
        end
        check_eq("bp_reached_word5", 32'(reset_hit), 32'd1);
        i_du_ready = 1'b1;
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;
        repeat (4) begin
            @(negedge i_clock);
            if (o_du_done) saw_done = 1'b1;
        end
        check_eq("abort_no_done", 32'(saw_done), 32'd0);
        check_eq("abort_idle_busy", 32'(o_busy), 32'd0);
        check_eq("abort_idle_valid", 32'(o_du_valid), 32'd0);
        load("abort_served", 32'h10, 2'b10, 1'b0, model[4], 1'b0);
`else
        // Without the dump port, dump controls are ignored and requests still served
        i_du_dump_start = 1'b1;
        i_du_ready = 1'b1;
        store("nodump_sw", 32'h30, 32'h0BADF00D, 2'b10, 1'b0);
        load("nodump_lw", 32'h30, 2'b10, 1'b0, 32'h0BADF00D, 1'b0);
        check_eq("nodump_busy", 32'(o_busy), 32'd0);
        check_eq("nodump_valid", 32'(o_du_valid), 32'd0);
        check_eq("nodump_done", 32'(o_du_done), 32'd0);
        check_eq("nodump_data", o_du_data, 32'd0);
        i_du_dump_start = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
